// File: rtl/cruise_cmd_panel_if.sv
// Dashboard-side bundle for the cruise command panel: raw switch levels and
// controller feedback in, conditioned levels and command strobes out.
interface cruise_cmd_panel_if;
  logic       raw_throttle;
  logic       raw_set;
  logic       raw_accel;
  logic       raw_coast;
  logic       raw_cancel;
  logic       raw_resume;
  logic       raw_brake;
  logic       cruisectrl_in;
  logic [7:0] speed_in;
  logic       throttle;
  logic       brake;
  logic       set;
  logic       accel;
  logic       coast;
  logic       cancel;
  logic       resume;
  logic       rejected;
  logic       conflict;

  modport master (
    output raw_throttle, raw_set, raw_accel, raw_coast, raw_cancel, raw_resume, raw_brake,
    output cruisectrl_in, speed_in,
    input  throttle, brake, set, accel, coast, cancel, resume, rejected, conflict
  );

  modport slave (
    input  raw_throttle, raw_set, raw_accel, raw_coast, raw_cancel, raw_resume, raw_brake,
    input  cruisectrl_in, speed_in,
    output throttle, brake, set, accel, coast, cancel, resume, rejected, conflict
  );
endinterface

// File: rtl/cruise_cmd_panel.sv
// Cruise command panel: synchronizes and debounces the driver switches, gates
// presses against controller feedback, arbitrates by priority and emits
// single-cycle command strobes. Brake holds a lockout state.
// Optional feature macro CRUISE_PANEL_AUTOREPEAT_EN adds accel/coast
// auto-repeat (AR_WAIT/AR_RPT states and the repeat counter).
module cruise_cmd_panel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_RATE     = 4,
  parameter int MIN_SET_SPEED   = 45,
  parameter int CNT_W           = 5
) (
  input logic             clk,
  input logic             reset,
  cruise_cmd_panel_if.slave bus
);

  localparam int I_THR = 0;
  localparam int I_SET = 1;
  localparam int I_ACC = 2;
  localparam int I_COA = 3;
  localparam int I_CAN = 4;
  localparam int I_RES = 5;
  localparam int I_BRK = 6;
  // Inputs that are commands (press-to-strobe); throttle and brake are levels.
  localparam logic [6:0] CMD_MASK = 7'b0111110;

`ifdef CRUISE_PANEL_AUTOREPEAT_EN
  typedef enum logic [1:0] {IDLE, LOCK, AR_WAIT, AR_RPT} state_t;
  logic [CNT_W-1:0] rpt_cnt, rpt_cnt_n;
  logic             rpt_key, rpt_key_n;   // 0: accel held, 1: coast held
  logic             ar_exit;
`else
  typedef enum logic {IDLE, LOCK} state_t;
  // Repeat timing has no effect in this build; tie it off.
  logic [CNT_W-1:0] unused_repeat_cfg;
  assign unused_repeat_cfg = CNT_W'(REPEAT_DELAY + REPEAT_RATE);
`endif

  state_t           state, state_n;
  logic [6:0]       raw, sync1, sync2, db, db_n, press, ok, grant;
  logic [CNT_W-1:0] db_cnt   [7];
  logic [CNT_W-1:0] db_cnt_n [7];
  logic             speed_ok, brake_n, conflict_n, reject_n, rpt_acc, rpt_coa;

  assign raw = {bus.raw_brake, bus.raw_resume, bus.raw_cancel, bus.raw_coast,
                bus.raw_accel, bus.raw_set, bus.raw_throttle};

  // Synchronizer flops and debounced levels with their run counters
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      for (int i = 0; i < 7; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      db    <= db_n;
      for (int i = 0; i < 7; i++) db_cnt[i] <= db_cnt_n[i];
    end
  end

  // Debounce: flip the level once the synchronized input has disagreed long enough
  always_comb begin
    for (int i = 0; i < 7; i++) begin
      db_n[i]     = db[i];
      db_cnt_n[i] = '0;
      if (sync2[i] != db[i]) begin
        if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) db_n[i] = ~db[i];
        else db_cnt_n[i] = db_cnt[i] + 1'b1;
      end
    end
  end

  // Decisions use the level being registered this edge so strobes line up with it.
  assign press      = db_n & ~db;
  assign brake_n    = db_n[I_BRK];
  assign conflict_n = db_n[I_ACC] & db_n[I_COA];
  assign speed_ok   = bus.speed_in > 8'(MIN_SET_SPEED);

  // Gate each press by controller state, then grant the highest-priority one
  always_comb begin
    ok    = '0;
    grant = '0;
    ok[I_CAN] = press[I_CAN] &  bus.cruisectrl_in & ~brake_n;
    ok[I_ACC] = press[I_ACC] &  bus.cruisectrl_in & ~brake_n & ~conflict_n;
    ok[I_COA] = press[I_COA] &  bus.cruisectrl_in & ~brake_n & ~conflict_n;
    ok[I_SET] = press[I_SET] & ~bus.cruisectrl_in & ~brake_n & speed_ok;
    ok[I_RES] = press[I_RES] & ~bus.cruisectrl_in & ~brake_n;
    if      (ok[I_CAN]) grant[I_CAN] = 1'b1;
    else if (ok[I_ACC]) grant[I_ACC] = 1'b1;
    else if (ok[I_COA]) grant[I_COA] = 1'b1;
    else if (ok[I_SET]) grant[I_SET] = 1'b1;
    else if (ok[I_RES]) grant[I_RES] = 1'b1;
  end

  assign reject_n = |(press & CMD_MASK & ~grant);

`ifdef CRUISE_PANEL_AUTOREPEAT_EN
  assign ar_exit = ~(rpt_key ? db_n[I_COA] : db_n[I_ACC]) | conflict_n |
                   ~bus.cruisectrl_in | press[I_CAN];

  // State register plus held-key and repeat counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rpt_cnt <= '0;
      rpt_key <= 1'b0;
    end else begin
      state   <= state_n;
      rpt_cnt <= rpt_cnt_n;
      rpt_key <= rpt_key_n;
    end
  end

  // Next state: brake lockout first, then new accel/coast press, then repeat timing
  always_comb begin
    state_n   = state;
    rpt_cnt_n = rpt_cnt;
    rpt_key_n = rpt_key;
    rpt_acc   = 1'b0;
    rpt_coa   = 1'b0;
    if (brake_n) begin
      state_n = LOCK;
    end else if (grant[I_ACC] | grant[I_COA]) begin
      state_n   = AR_WAIT;
      rpt_cnt_n = '0;
      rpt_key_n = grant[I_COA];
    end else begin
      case (state)
        AR_WAIT, AR_RPT: begin
          if (ar_exit) begin
            state_n = IDLE;
          end else if (rpt_cnt == ((state == AR_WAIT) ? CNT_W'(REPEAT_DELAY - 1)
                                                     : CNT_W'(REPEAT_RATE - 1))) begin
            state_n   = AR_RPT;
            rpt_cnt_n = '0;
            rpt_acc   = ~rpt_key;
            rpt_coa   = rpt_key;
          end else begin
            rpt_cnt_n = rpt_cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
`else
  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state: lockout follows the debounced brake level
  always_comb begin
    state_n = state;
    rpt_acc = 1'b0;
    rpt_coa = 1'b0;
    case (state)
      IDLE:    if (brake_n) state_n = LOCK;
      default: if (!brake_n) state_n = IDLE;
    endcase
  end
`endif

  // Registered outputs; throttle is forced low while locked out by brake
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.throttle <= 1'b0;
      bus.brake    <= 1'b0;
      bus.set      <= 1'b0;
      bus.accel    <= 1'b0;
      bus.coast    <= 1'b0;
      bus.cancel   <= 1'b0;
      bus.resume   <= 1'b0;
      bus.rejected <= 1'b0;
      bus.conflict <= 1'b0;
    end else begin
      bus.throttle <= db_n[I_THR] & (state_n != LOCK);
      bus.brake    <= brake_n;
      bus.set      <= grant[I_SET];
      bus.accel    <= grant[I_ACC] | rpt_acc;
      bus.coast    <= grant[I_COA] | rpt_coa;
      bus.cancel   <= grant[I_CAN];
      bus.resume   <= grant[I_RES];
      bus.rejected <= reject_n;
      bus.conflict <= conflict_n;
    end
  end

endmodule

// File: tb/tb_cruise_cmd_panel.sv
// Scoreboard bench for cruise_cmd_panel: directed scenarios plus random switch
// activity, compared every cycle against a timestamp/history reference model.
module tb_cruise_cmd_panel;
  localparam int DEB    = 4;
  localparam int RDLY   = 16;
  localparam int RRATE  = 4;
  localparam int MINSPD = 45;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cruise_cmd_panel_if bus();

  cruise_cmd_panel #(
    .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE),
    .MIN_SET_SPEED(MINSPD), .CNT_W(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct { int edge_no; logic [8:0] v; } exp_t;
  exp_t q[$];

  int cyc = 0;
  int checks = 0;
  int passes = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus state: index 0 thr,1 set,2 acc,3 coa,4 can,5 res,6 brk
  logic [6:0] rin = '0;
  bit         cr = 1'b0;
  logic [7:0] sp = 8'd0;
  bit         rs = 1'b1;

  // Reference model state
  bit hist[7][$];
  bit mdb[7];
  int ar_key = -1;
`ifdef CRUISE_PANEL_AUTOREPEAT_EN
  int ar_next = 0;
`endif

  bit rec_on = 1'b0;
  int rec_base = 0;
  int acc_seen[$];
  int acc_exp[$];

  function automatic bit gate_ok(int idx, bit c, logic [7:0] s, bit brk, bit conf);
    if (brk) return 1'b0;
    case (idx)
      4:       return c;
      2, 3:    return c && !conf;
      1:       return !c && (int'(s) > MINSPD);
      5:       return !c;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step(output logic [8:0] v);
    bit nd[7];
    bit pr[7];
    int order[5] = '{4, 2, 3, 1, 5};
    int win = -1;
    int rep = -1;
    bit rej = 1'b0;
    bit all_diff, nbrk, nconf;
    int e = cyc + 1;
    v = '0;
    if (rs) begin
      for (int i = 0; i < 7; i++) begin
        hist[i].delete();
        repeat (DEB + 2) hist[i].push_back(1'b0);
        mdb[i] = 1'b0;
      end
      ar_key = -1;
      return;
    end
    // Level flips when the last DEB synchronized samples (raw from 2 edges back) all differ
    for (int i = 0; i < 7; i++) begin
      hist[i].push_front(rin[i]);
      void'(hist[i].pop_back());
      all_diff = 1'b1;
      for (int k = 2; k < DEB + 2; k++) if (hist[i][k] == mdb[i]) all_diff = 1'b0;
      nd[i] = all_diff ? !mdb[i] : mdb[i];
      pr[i] = nd[i] && !mdb[i];
    end
    nbrk  = nd[6];
    nconf = nd[2] && nd[3];
    foreach (order[j]) begin
      if (pr[order[j]]) begin
        if (win < 0 && gate_ok(order[j], cr, sp, nbrk, nconf)) win = order[j];
        else rej = 1'b1;
      end
    end
`ifdef CRUISE_PANEL_AUTOREPEAT_EN
    if (nbrk) ar_key = -1;
    else if (win == 2 || win == 3) begin
      ar_key  = win;
      ar_next = e + RDLY;
    end else if (ar_key >= 0) begin
      if (!nd[ar_key] || nconf || !cr || pr[4]) ar_key = -1;
      else if (e == ar_next) begin
        rep     = ar_key;
        ar_next = e + RRATE;
      end
    end
`endif
    v = {nd[0] && !nbrk, nbrk, win == 1, (win == 2) || (rep == 2),
         (win == 3) || (rep == 3), win == 4, win == 5, rej, nconf};
    for (int i = 0; i < 7; i++) mdb[i] = nd[i];
  endtask

  task automatic tick();
    exp_t x;
    reset            = rs;
    bus.raw_throttle = rin[0];
    bus.raw_set      = rin[1];
    bus.raw_accel    = rin[2];
    bus.raw_coast    = rin[3];
    bus.raw_cancel   = rin[4];
    bus.raw_resume   = rin[5];
    bus.raw_brake    = rin[6];
    bus.cruisectrl_in = cr;
    bus.speed_in     = sp;
    x.edge_no = cyc + 1;
    model_step(x.v);
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Monitor: compare the DUT outputs against the expectation queued for this edge
  always @(negedge clk) begin
    logic [8:0] got;
    got = {bus.throttle, bus.brake, bus.set, bus.accel, bus.coast,
           bus.cancel, bus.resume, bus.rejected, bus.conflict};
    if (rec_on && bus.accel === 1'b1) acc_seen.push_back(cyc - rec_base);
    if (q.size() > 0 && q[0].edge_no == cyc) begin
      checks++;
      if (got === q[0].v) passes++;
      else $display("FAIL outputs edge %0d: got %b expected %b (thr brk set acc coa can res rej cfl)",
                    cyc, got, q[0].v);
      void'(q.pop_front());
    end
  end

  initial begin
    int rng[7] = '{20, 50, 40, 40, 60, 50, 90};
    reset = 1'b1;
    bus.raw_throttle = 1'b0; bus.raw_set = 1'b0; bus.raw_accel = 1'b0;
    bus.raw_coast = 1'b0; bus.raw_cancel = 1'b0; bus.raw_resume = 1'b0;
    bus.raw_brake = 1'b0; bus.cruisectrl_in = 1'b0; bus.speed_in = 8'd0;
    @(posedge clk);
    #1;
    rs = 1'b1; run(2);
    rs = 1'b0;

    // Set: short glitch then a stable press, accepted and then rejected on speed
    cr = 1'b0; sp = 8'd50;
    rin[1] = 1'b1; run(3); rin[1] = 1'b0; run(3);
    rin[1] = 1'b1; run(10); rin[1] = 1'b0; run(10);
    sp = 8'd45;
    rin[1] = 1'b1; run(10); rin[1] = 1'b0; run(10);

    // Accel held for 40 cycles with cruise engaged
    cr = 1'b1; run(8);
    rec_base = cyc; rec_on = 1'b1;
    rin[2] = 1'b1; run(40); rin[2] = 1'b0; run(20);
    rec_on = 1'b0;
`ifdef CRUISE_PANEL_AUTOREPEAT_EN
    acc_exp = '{6, 22, 26, 30, 34, 38, 42};
`else
    acc_exp = '{6};
`endif
    checks++;
    if (acc_seen.size() == acc_exp.size()) passes++;
    else $display("FAIL accel_strobe_count: got %0d required %0d", acc_seen.size(), acc_exp.size());
    for (int i = 0; i < acc_exp.size() && i < acc_seen.size(); i++) begin
      checks++;
      if (acc_seen[i] == acc_exp[i]) passes++;
      else $display("FAIL accel_strobe_time[%0d]: got %0d required %0d", i, acc_seen[i], acc_exp[i]);
    end

    // Brake during repeat, then a resume press while braked
    rin[2] = 1'b1; run(30); rin[6] = 1'b1; run(10);
    rin[5] = 1'b1; run(10); rin[5] = 1'b0; rin[2] = 1'b0; run(10);
    rin[6] = 1'b0; run(10);

    // Accel and coast together
    rin[2] = 1'b1; rin[3] = 1'b1; run(12); rin[2] = 1'b0; rin[3] = 1'b0; run(10);

    // Cancel and accel in the same cycle
    rin[4] = 1'b1; rin[2] = 1'b1; run(10); rin[4] = 1'b0; rin[2] = 1'b0; run(10);

    // Reset pulse while accel is repeating
    rin[2] = 1'b1; run(30); rs = 1'b1; tick(); rs = 1'b0;
    run(12); rin[2] = 1'b0; run(10);

    // Random switch activity
    for (int n = 0; n < 2500; n++) begin
      for (int i = 0; i < 7; i++)
        if ($urandom_range(0, rng[i] - 1) == 0) rin[i] = ~rin[i];
      if ($urandom_range(0, 99) == 0) cr = ~cr;
      if ($urandom_range(0, 19) == 0) sp = 8'($urandom_range(40, 60));
      rs = ($urandom_range(0, 599) == 0);
      tick();
    end
    rs = 1'b0; rin = '0; run(12);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
